// File: rtl/lc3_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lc3_mem_pkg -- MMIO addresses and responder state encoding  | rev 1.0
// ============================================================================
package lc3_mem_pkg;

  localparam logic [15:0] C_ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] C_ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] C_ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] C_ADDR_DDR  = 16'hFE06;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } resp_state_e;

  function automatic logic is_mmio(input logic [15:0] a);
    return (a == C_ADDR_KBSR) || (a == C_ADDR_KBDR) ||
           (a == C_ADDR_DSR)  || (a == C_ADDR_DDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lc3_mem_array -- single-port 16-bit RAM, sync write / async read  | rev 1.0
// ============================================================================
module lc3_mem_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lc3_mem_responder -- LC-3 RAM + keyboard/display MMIO bus responder | rev 1.0
// ============================================================================
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        bus_err,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data,
  input  logic        ddr_ack
);

  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam logic [31:0] RAM_WORDS = 32'd1 << MEM_AW;

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        kbsr_q, kbsr_d;
  logic [7:0]  kchar_q, kchar_d;
  logic        dsr_q, dsr_d;
  logic        dvalid_q, dvalid_d;
  logic [7:0]  ddata_q, ddata_d;

  logic        in_resp, hit_mmio, hit_ram, kbdr_rd, ddr_wr, ram_we;
  logic [15:0] ram_rdata;

  // Decode works entirely off the captured address so it is stable through WAIT/RESP.
  assign in_resp  = (state_q == S_RESP);
  assign hit_mmio = is_mmio(addr_q);
  assign hit_ram  = !hit_mmio && ({16'b0, addr_q} < RAM_WORDS);
  assign kbdr_rd  = in_resp && !we_q && (addr_q == C_ADDR_KBDR);
  assign ddr_wr   = in_resp && we_q && (addr_q == C_ADDR_DDR);
  assign ram_we   = in_resp && we_q && hit_ram;

  lc3_mem_array #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (addr_q[MEM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A KBDR read frees the buffer first, so a same-cycle strobe is accepted.
  always_comb begin
    kbsr_d   = kbsr_q;
    kchar_d  = kchar_q;
    dsr_d    = dsr_q;
    dvalid_d = dvalid_q;
    ddata_d  = ddata_q;
    if (kbdr_rd) begin
      kbsr_d = 1'b0;
    end
    if (kbd_valid && (!kbsr_q || kbdr_rd)) begin
      kchar_d = kbd_data;
      kbsr_d  = 1'b1;
    end
    if (ddr_ack && dvalid_q) begin
      dvalid_d = 1'b0;
      dsr_d    = 1'b1;
    end
    if (ddr_wr && dsr_q) begin
      ddata_d  = wdata_q[7:0];
      dvalid_d = 1'b1;
      dsr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      kbsr_q   <= 1'b0;
      kchar_q  <= 8'h00;
      dsr_q    <= 1'b1;
      dvalid_q <= 1'b0;
      ddata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      kbsr_q   <= kbsr_d;
      kchar_q  <= kchar_d;
      dsr_q    <= dsr_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (in_resp && !we_q) begin
      if (hit_ram)                          rdata = ram_rdata;
      else if (addr_q == C_ADDR_KBSR)       rdata = {kbsr_q, 15'b0};
      else if (addr_q == C_ADDR_KBDR)       rdata = {8'b0, kchar_q};
      else if (addr_q == C_ADDR_DSR)        rdata = {dsr_q, 15'b0};
    end
  end

  assign ready     = in_resp;
  assign bus_err   = in_resp && ((!hit_ram && !hit_mmio) || (ddr_wr && !dsr_q));
  assign ddr_valid = dvalid_q;
  assign ddr_data  = ddata_q;

endmodule
`default_nettype wire
